// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the CPU datapath blocks.
//   DATA_W              : native datapath width
//   FWD_REG/FWD_EX/...  : operand-forwarding select encodings. Every
//                         forwarding mux instance uses these values.
//   upd_e               : what the operand pipeline register does at an edge
//   sel_in_range()      : true when a binary select addresses a real input
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 32;

    // Forwarding-mux select encodings.
    localparam int FWD_REG = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;

    // Register update action. Listed in increasing priority.
    typedef enum logic [1:0] {
        UPD_IDLE    = 2'd0,
        UPD_CAPTURE = 2'd1,
        UPD_STALL   = 2'd2,
        UPD_FLUSH   = 2'd3
    } upd_e;

    // A select can only exceed the input count when the count is not a
    // power of two. The compare is done on ints so that it stays
    // warning-free when every encoding is legal.
    function automatic logic sel_in_range(input int sel, input int num_in);
        return (sel < num_in);
    endfunction

endpackage

// File: rtl/operand_mux_pipe_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for per-source selection statistics.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   clr   : synchronous clear; wins over a same-cycle inc
//   count : current value; sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = (count == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/operand_mux_pipe.sv
// ---------------------------------------------------------------------------
// operand_mux_pipe
// N-to-1 operand select mux followed by a pipeline register. The register
// supports valid, stall-hold and flush. Each source has a saturating
// counter that records how often it was selected.
//
// Parameters
//   WIDTH       : data width of each input and of out
//   NUM_IN      : number of selectable inputs (2..16)
//   SEL_W       : select width, derived from NUM_IN
//   CNT_W       : width of each selection counter
//   DEFAULT_SEL : input used when Ctrl_Sel is out of range
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   In_data     : flattened inputs, input i at [i*WIDTH +: WIDTH]
//   Ctrl_Sel    : binary select
//   In_valid    : inputs/select meaningful this cycle
//   Ctrl_Stall  : hold registered state
//   Ctrl_Flush  : insert a bubble (beats Stall)
//   Ctrl_CntClr : synchronous clear of every counter
//   out         : registered selected data
//   out_valid   : out holds a captured value
//   out_sel     : registered index actually used
//   sel_err     : one-cycle pulse after an out-of-range capture
//   cnt_bus     : flattened counters, counter i at [i*CNT_W +: CNT_W]
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module operand_mux_pipe
    import cpu_pkg::*;
#(
    parameter int WIDTH       = DATA_W,
    parameter int NUM_IN      = 4,
    parameter int SEL_W       = $clog2(NUM_IN),
    parameter int CNT_W       = 16,
    parameter int DEFAULT_SEL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] In_data,
    input  logic [SEL_W-1:0]        Ctrl_Sel,
    input  logic                    In_valid,
    input  logic                    Ctrl_Stall,
    input  logic                    Ctrl_Flush,
    input  logic                    Ctrl_CntClr,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err,
    output logic [NUM_IN*CNT_W-1:0] cnt_bus
);

    upd_e              action;
    logic              sel_ok;
    logic [SEL_W-1:0]  eff_sel;
    logic [WIDTH-1:0]  sel_data;
    logic [NUM_IN-1:0] inc_vec;

    // Out-of-range selects fall back to DEFAULT_SEL.
    assign sel_ok  = sel_in_range(int'(Ctrl_Sel), NUM_IN);
    assign eff_sel = sel_ok ? Ctrl_Sel : SEL_W'(DEFAULT_SEL);

    // Flush > Stall > capture > idle.
    always_comb begin
        action = UPD_IDLE;
        if (Ctrl_Flush) begin
            action = UPD_FLUSH;
        end else if (Ctrl_Stall) begin
            action = UPD_STALL;
        end else if (In_valid) begin
            action = UPD_CAPTURE;
        end
    end

    // The loop visits only real inputs. An out-of-range index therefore
    // can never read past the end of In_data.
    always_comb begin
        sel_data = In_data[DEFAULT_SEL*WIDTH +: WIDTH];
        for (int i = 0; i < NUM_IN; i++) begin
            if (eff_sel == SEL_W'(i)) begin
                sel_data = In_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Only in-range captures are counted. A fallback to DEFAULT_SEL is an
    // error, not a real use of that source.
    always_comb begin
        inc_vec = '0;
        if ((action == UPD_CAPTURE) && sel_ok) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (Ctrl_Sel == SEL_W'(i)) begin
                    inc_vec[i] = 1'b1;
                end
            end
        end
    end

    // Idle keeps out/out_sel so a later stage can still read the last
    // value. Only the valid flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            sel_err   <= 1'b0;
        end else begin
            case (action)
                UPD_FLUSH: begin
                    out       <= '0;
                    out_valid <= 1'b0;
                    out_sel   <= '0;
                    sel_err   <= 1'b0;
                end
                UPD_STALL: begin
                    sel_err   <= 1'b0;
                end
                UPD_CAPTURE: begin
                    out       <= sel_data;
                    out_valid <= 1'b1;
                    out_sel   <= eff_sel;
                    sel_err   <= !sel_ok;
                end
                default: begin
                    out_valid <= 1'b0;
                    sel_err   <= 1'b0;
                end
            endcase
        end
    end

    // One counter per source. The clear ignores Stall and Flush.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[g]),
            .clr   (Ctrl_CntClr),
            .count (cnt_bus[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_operand_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_operand_mux_pipe
// Directed bench for operand_mux_pipe. It uses two instances:
//   dut_a : NUM_IN=4, CNT_W=4, DEFAULT_SEL=0 (sweep, stall/flush, idle,
//           clear, saturation, asynchronous reset)
//   dut_b : NUM_IN=3, CNT_W=16, DEFAULT_SEL=1 (out-of-range select)
// Inputs change 1 time unit after a rising edge. Outputs are read at the
// same point, so each read shows the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_operand_mux_pipe;

    logic clk;
    logic rst;

    // dut_a signals
    logic [127:0] a_data;
    logic [1:0]   a_sel;
    logic         a_valid, a_stall, a_flush, a_clr;
    logic [31:0]  a_out;
    logic         a_out_valid;
    logic [1:0]   a_out_sel;
    logic         a_sel_err;
    logic [15:0]  a_cnt;

    // dut_b signals
    logic [95:0]  b_data;
    logic [1:0]   b_sel;
    logic         b_valid, b_stall, b_flush, b_clr;
    logic [31:0]  b_out;
    logic         b_out_valid;
    logic [1:0]   b_out_sel;
    logic         b_sel_err;
    logic [47:0]  b_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    operand_mux_pipe #(
        .WIDTH       (32),
        .NUM_IN      (4),
        .CNT_W       (4),
        .DEFAULT_SEL (0)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .In_data     (a_data),
        .Ctrl_Sel    (a_sel),
        .In_valid    (a_valid),
        .Ctrl_Stall  (a_stall),
        .Ctrl_Flush  (a_flush),
        .Ctrl_CntClr (a_clr),
        .out         (a_out),
        .out_valid   (a_out_valid),
        .out_sel     (a_out_sel),
        .sel_err     (a_sel_err),
        .cnt_bus     (a_cnt)
    );

    operand_mux_pipe #(
        .WIDTH       (32),
        .NUM_IN      (3),
        .CNT_W       (16),
        .DEFAULT_SEL (1)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .In_data     (b_data),
        .Ctrl_Sel    (b_sel),
        .In_valid    (b_valid),
        .Ctrl_Stall  (b_stall),
        .Ctrl_Flush  (b_flush),
        .Ctrl_CntClr (b_clr),
        .out         (b_out),
        .out_valid   (b_out_valid),
        .out_sel     (b_out_sel),
        .sel_err     (b_sel_err),
        .cnt_bus     (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [1:0]   sel;
        logic         stall;
        logic         flush;
        logic         clr;
        logic [127:0] data;
        logic [31:0]  exp_out;
        logic         exp_valid;
        logic [1:0]   exp_sel;
        logic [15:0]  exp_cnt;
    } vec_t;

    localparam logic [127:0] D1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] D2 = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    localparam logic [127:0] D3 = {32'h0, 32'h0, 32'h12345678, 32'h0};
    localparam logic [95:0]  DB = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

    vec_t vecs [17];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] sel, input logic stall,
                                 input logic flush, input logic clr, input logic [127:0] data);
        a_valid = valid;
        a_sel   = sel;
        a_stall = stall;
        a_flush = flush;
        a_clr   = clr;
        a_data  = data;
    endtask

    task automatic applyStimulusB(input logic valid, input logic [1:0] sel, input logic stall);
        b_valid = valid;
        b_sel   = sel;
        b_stall = stall;
        b_flush = 1'b0;
        b_clr   = 1'b0;
        b_data  = DB;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each counter is 4 bits: {c3,c2,c1,c0}.
        //          valid sel   stall flush clr  data  exp_out        v     sel   cnt
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, D1, 32'h11111111, 1'b1, 2'd0, 16'h0001};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, D1, 32'h22222222, 1'b1, 2'd1, 16'h0011};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, D1, 32'h33333333, 1'b1, 2'd2, 16'h0111};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, D1, 32'h44444444, 1'b1, 2'd3, 16'h1111};
        vecs[4]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, D1, 32'h33333333, 1'b1, 2'd2, 16'h1211};
        vecs[5]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, D2, 32'h33333333, 1'b1, 2'd2, 16'h1211};
        vecs[6]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, D2, 32'h33333333, 1'b1, 2'd2, 16'h1211};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, D2, 32'h33333333, 1'b1, 2'd2, 16'h1211};
        vecs[8]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, D2, 32'h00000000, 1'b0, 2'd0, 16'h1211};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, D2, 32'h00000000, 1'b0, 2'd0, 16'h1211};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, D3, 32'h12345678, 1'b1, 2'd1, 16'h1221};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, D2, 32'h12345678, 1'b0, 2'd1, 16'h1221};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D1, 32'h12345678, 1'b0, 2'd1, 16'h1221};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, D2, 32'h00000000, 1'b0, 2'd0, 16'h0000};
        vecs[14] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, D2, 32'hDDDDDDDD, 1'b1, 2'd0, 16'h0001};
        vecs[15] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, D2, 32'hDDDDDDDD, 1'b1, 2'd0, 16'h0000};
        vecs[16] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, D2, 32'hBBBBBBBB, 1'b1, 2'd2, 16'h0100};

        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulusB(1'b0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out",       64'(a_out),       64'h0);
        checkOutput("reset out_valid", 64'(a_out_valid), 64'h0);
        checkOutput("reset out_sel",   64'(a_out_sel),   64'h0);
        checkOutput("reset sel_err",   64'(a_sel_err),   64'h0);
        checkOutput("reset cnt_bus",   64'(a_cnt),       64'h0);
        checkOutput("reset b cnt_bus", 64'(b_cnt),       64'h0);
        rst = 1'b0;

        // Load a value and a count, then reset between edges.
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
        stepClock();
        checkOutput("pre-reset out", 64'(a_out), 64'hDEADBEEF);
        checkOutput("pre-reset cnt", 64'(a_cnt), 64'h0010);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async reset out",       64'(a_out),       64'h0);
        checkOutput("async reset out_valid", 64'(a_out_valid), 64'h0);
        checkOutput("async reset cnt_bus",   64'(a_cnt),       64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] table vectors on dut_a");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sel, vecs[i].stall,
                          vecs[i].flush, vecs[i].clr, vecs[i].data);
            stepClock();
            checkOutput($sformatf("row%0d out", i),       64'(a_out),       64'(vecs[i].exp_out));
            checkOutput($sformatf("row%0d out_valid", i), 64'(a_out_valid), 64'(vecs[i].exp_valid));
            checkOutput($sformatf("row%0d out_sel", i),   64'(a_out_sel),   64'(vecs[i].exp_sel));
            checkOutput($sformatf("row%0d sel_err", i),   64'(a_sel_err),   64'h0);
            checkOutput($sformatf("row%0d cnt_bus", i),   64'(a_cnt),       64'(vecs[i].exp_cnt));
        end

        // Saturation. c0 starts at 0 (c2 = 1). After 15 captures c0 must
        // sit at 15 and stay there.
        $display("[TB] saturation on dut_a");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, D1);
            stepClock();
            if (k == 14) checkOutput("sat c0 at 15", 64'(a_cnt[3:0]), 64'd15);
            if (k == 15) checkOutput("sat c0 no wrap", 64'(a_cnt[3:0]), 64'd15);
        end
        checkOutput("sat cnt_bus after 20", 64'(a_cnt), 64'h010F);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, D1);
        stepClock();
        checkOutput("clear beats inc", 64'(a_cnt), 64'h0000);
        checkOutput("clear capture out", 64'(a_out), 64'h11111111);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, D1);
        stepClock();
        checkOutput("count after clear", 64'(a_cnt), 64'h0001);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, D1);

        // Out-of-range select on the 3-input instance.
        $display("[TB] out-of-range select on dut_b");
        applyStimulusB(1'b1, 2'd2, 1'b0);
        stepClock();
        checkOutput("b sel2 out",     64'(b_out),     64'hC2C2C2C2);
        checkOutput("b sel2 sel_err", 64'(b_sel_err), 64'h0);
        checkOutput("b sel2 cnt",     64'(b_cnt),     {16'h0, 16'h0001, 16'h0000, 16'h0000});
        applyStimulusB(1'b1, 2'd3, 1'b0);
        stepClock();
        checkOutput("b oor out",       64'(b_out),       64'hB1B1B1B1);
        checkOutput("b oor out_sel",   64'(b_out_sel),   64'd1);
        checkOutput("b oor out_valid", 64'(b_out_valid), 64'd1);
        checkOutput("b oor sel_err",   64'(b_sel_err),   64'd1);
        checkOutput("b oor cnt",       64'(b_cnt),       {16'h0, 16'h0001, 16'h0000, 16'h0000});
        applyStimulusB(1'b0, 2'd3, 1'b0);
        stepClock();
        checkOutput("b err pulse ends", 64'(b_sel_err),   64'd0);
        checkOutput("b idle out holds", 64'(b_out),       64'hB1B1B1B1);
        checkOutput("b idle valid",     64'(b_out_valid), 64'd0);
        applyStimulusB(1'b1, 2'd3, 1'b0);
        stepClock();
        checkOutput("b oor again err", 64'(b_sel_err), 64'd1);
        applyStimulusB(1'b1, 2'd3, 1'b1);
        stepClock();
        checkOutput("b stall clears err", 64'(b_sel_err), 64'd0);
        checkOutput("b stall holds out",  64'(b_out),     64'hB1B1B1B1);
        applyStimulusB(1'b1, 2'd0, 1'b0);
        stepClock();
        checkOutput("b sel0 out", 64'(b_out), 64'hA0A0A0A0);
        checkOutput("b sel0 cnt", 64'(b_cnt), {16'h0, 16'h0001, 16'h0000, 16'h0001});
        applyStimulusB(1'b0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
